mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port latch_mem between two requesters: the SPI host path (HOST) and the cpu fetch/load/store
//  path (CPU). Sequences every access with correct latch timing (addr/data setup, one-cycle we pulse, hold) and
//  returns a one-cycle ack per requester. mode_i selects the policy:
//  - command mode: HOST strict priority;
//  - data mode: round-robin.
// PARAMETERS
//  NUM_WORDS  64                  depth of latch_mem
//  DATA_W     8                   data width
//  ADDR_W     $clog2(NUM_WORDS)   address width (derived; do not override)
// PORTS
//  clk_i          in   1       clock
//  rst_i          in   1       synchronous reset, active-high
//  mode_i         in   1       0 = command mode (HOST priority); 1 = data mode (round-robin)
//  host_stb_i     in   1       HOST request; held until host_ack_o
//  host_we_i      in   1       HOST write (1) / read (0)
//  host_addr_i    in   ADDR_W  HOST address
//  host_wdata_i   in   DATA_W  HOST write data
//  host_ack_o     out  1       one-cycle completion pulse
//  host_rdata_o   out  DATA_W  read data; valid while host_ack_o=1
//  cpu_stb_i      in   1       CPU request; same rules as HOST
//  cpu_we_i       in   1       CPU write / read
//  cpu_addr_i     in   ADDR_W  CPU address
//  cpu_wdata_i    in   DATA_W  CPU write data
//  cpu_ack_o      out  1       one-cycle completion pulse
//  cpu_rdata_o    out  DATA_W  read data; valid while cpu_ack_o=1
//  mem_addr_o     out  ADDR_W  to latch_mem addr_i
//  mem_wdata_o    out  DATA_W  to latch_mem data_i
//  mem_we_o       out  1       to latch_mem we_i; registered, glitch-free
//  mem_rdata_i    in   DATA_W  from latch_mem data_o
//  host_wait_o    out  8       saturating HOST wait-cycle count (see CONFIGURATION)
//  cpu_wait_o     out  8       saturating CPU wait-cycle count
// BEHAVIOUR
//  - Reset: state IDLE, rr_last=HOST (CPU wins first round-robin tie), all outputs 0, wait counters 0.
//  - Reset mid-transaction aborts it: no ack issued, mem_we_o=0 on the following cycle.
//  - FSM states (all outputs registered):
//    - IDLE: arbitrate among stb_i inputs, latch winner's id/we/addr/wdata. Next state: READ if we=0, else WR_SETUP.
//    - READ: mem_addr_o driven. Next cycle ACK: winner ack=1, rdata captured from mem_rdata_i.
//    - WR_SETUP: addr/wdata driven, we=0.
//    - WR_PULSE: we=1.
//    - WR_HOLD: we=0, addr/wdata held.
//    - ACK: winner ack=1. Next state IDLE.
//  - Latency from stb sampled in IDLE to ack: read 2 cycles, write 4 cycles.
//  - Back-to-back: in the ACK cycle the arbiter ignores both stb inputs. A stb still high in the cycle after ack
//    is a new request.
//  - Arbitration, mode_i=0: HOST wins whenever host_stb_i=1.
//  - Arbitration, mode_i=1: on a tie the winner is the requester not equal to rr_last; rr_last updates on every grant.
//  - mode_i is sampled only in IDLE. A change mid-access affects the next grant only.
//  - The request is latched at grant. Requester input changes during the access are ignored; the requester must
//    hold them steady anyway.
//  - rdata outputs hold their last value outside ack. A write ack leaves rdata unchanged.
//  - The losing requester is stalled with no ack; no request is ever dropped.
// CONFIGURATION
//  MEM_ARB_WAIT_CNT_EN
//  - Defined: a requester's counter increments (saturating at 255) each cycle its stb_i=1 and it is not the
//    active grantee. It clears on that requester's ack.
//  - Undefined: host_wait_o/cpu_wait_o are tied to 0 and the counter logic is not built.
// STRUCTURE
//  - mem_arb_pkg:
//    - state_e {IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, ACK}
//    - req_e {REQ_HOST, REQ_CPU}
//    - WAIT_CNT_W = 8
//  - Sub-module mem_arb_pick: combinational 2-way picker.
//    - Inputs: stb[1:0], mode, rr_last. Output: grant id + valid.
//    - Reused by future port-bus arbitration.
// TESTING
//  1. mode=1, HOST write 0x15<-0xA5, then read 0x15.
//     - Write: mem_we_o high exactly 1 cycle, ack 4 cycles after grant.
//     - Read: host_rdata_o=0xA5 with ack 2 cycles after grant.
//  2. mode=1, both stb high continuously from reset.
//     - Grants CPU, HOST, CPU, HOST…; each ack pulses 1 cycle; no starvation.
//  3. mode=0, both stb high.
//     - Only HOST acked while host_stb_i stays high.
//     - CPU acked within 5 cycles of host_stb_i falling.
//  4. rst_i asserted during WR_PULSE.
//     - Next cycle: mem_we_o=0, no ack, state IDLE.
//     - Same request re-presented completes normally.
//  5. MEM_ARB_WAIT_CNT_EN defined, CPU blocked by 300 cycles of HOST traffic (mode=0).
//     - cpu_wait_o saturates at 255, clears to 0 after cpu ack.
//     - Macro undefined: both counters are always 0.
//  6. Requester changes addr/wdata while waiting for ack.
//     - The access uses the values latched at grant; mem_addr_o is stable for the whole access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the latch_mem arbiter: FSM states, requester ids and the
// wait-counter width.
package mem_arb_pkg;

  localparam int WAIT_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    ACK      = 3'd5
  } state_e;

  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_CPU  = 1'b1
  } req_e;

  function automatic req_e other_req(input req_e r);
    return (r == REQ_HOST) ? REQ_CPU : REQ_HOST;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way picker: strict HOST priority or round-robin on a tie.
// stb_i[0] is HOST, stb_i[1] is CPU.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] stb_i,
  input  logic       mode_i,
  input  req_e       rr_last_i,
  output req_e       grant_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |stb_i;
    grant_o = REQ_HOST;
    if (&stb_i) begin
      grant_o = mode_i ? other_req(rr_last_i) : REQ_HOST;
    end else if (stb_i[1]) begin
      grant_o = REQ_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates HOST and CPU access to the single-port latch_mem and sequences
// latch timing. Optional wait counters: define MEM_ARB_WAIT_CNT_EN.
//
// state    | meaning
// IDLE     | arbitrate, latch winner's request
// READ     | address driven, data captured at end of cycle
// WR_SETUP | address/data driven, we low
// WR_PULSE | we high for exactly one cycle
// WR_HOLD  | we low, address/data held
// ACK      | one-cycle ack to the winner, stb inputs ignored
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_WORDS = 64,
  parameter  int DATA_W    = 8,
  localparam int ADDR_W    = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mode_i,
  input  logic                  host_stb_i,
  input  logic                  host_we_i,
  input  logic [ADDR_W-1:0]     host_addr_i,
  input  logic [DATA_W-1:0]     host_wdata_i,
  output logic                  host_ack_o,
  output logic [DATA_W-1:0]     host_rdata_o,
  input  logic                  cpu_stb_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_W-1:0]     cpu_addr_i,
  input  logic [DATA_W-1:0]     cpu_wdata_i,
  output logic                  cpu_ack_o,
  output logic [DATA_W-1:0]     cpu_rdata_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic                  mem_we_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic [WAIT_CNT_W-1:0] host_wait_o,
  output logic [WAIT_CNT_W-1:0] cpu_wait_o
);

  state_e              r_state;
  req_e                r_id;
  req_e                r_rr_last;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_mem_we;
  logic                r_host_ack;
  logic                r_cpu_ack;
  logic [DATA_W-1:0]   r_host_rdata;
  logic [DATA_W-1:0]   r_cpu_rdata;

  req_e                w_pick_id;
  logic                w_pick_valid;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  mem_arb_pick u_pick (
    .stb_i     ({cpu_stb_i, host_stb_i}),
    .mode_i    (mode_i),
    .rr_last_i (r_rr_last),
    .grant_o   (w_pick_id),
    .valid_o   (w_pick_valid)
  );

  assign w_sel_we    = (w_pick_id == REQ_CPU) ? cpu_we_i    : host_we_i;
  assign w_sel_addr  = (w_pick_id == REQ_CPU) ? cpu_addr_i  : host_addr_i;
  assign w_sel_wdata = (w_pick_id == REQ_CPU) ? cpu_wdata_i : host_wdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_id         <= REQ_HOST;
      r_rr_last    <= REQ_HOST;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_we     <= 1'b0;
      r_host_ack   <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_host_rdata <= '0;
      r_cpu_rdata  <= '0;
    end else begin
      r_mem_we   <= 1'b0;
      r_host_ack <= 1'b0;
      r_cpu_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_id      <= w_pick_id;
            r_rr_last <= w_pick_id;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_state   <= w_sel_we ? WR_SETUP : READ;
          end
        end
        READ: begin
          r_state <= ACK;
          if (r_id == REQ_CPU) begin
            r_cpu_ack   <= 1'b1;
            r_cpu_rdata <= mem_rdata_i;
          end else begin
            r_host_ack   <= 1'b1;
            r_host_rdata <= mem_rdata_i;
          end
        end
        WR_SETUP: begin
          r_state  <= WR_PULSE;
          r_mem_we <= 1'b1;
        end
        WR_PULSE: r_state <= WR_HOLD;
        WR_HOLD: begin
          r_state <= ACK;
          if (r_id == REQ_CPU) r_cpu_ack  <= 1'b1;
          else                 r_host_ack <= 1'b1;
        end
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign mem_we_o     = r_mem_we;
  assign host_ack_o   = r_host_ack;
  assign cpu_ack_o    = r_cpu_ack;
  assign host_rdata_o = r_host_rdata;
  assign cpu_rdata_o  = r_cpu_rdata;

`ifdef MEM_ARB_WAIT_CNT_EN
  logic [WAIT_CNT_W-1:0] r_host_wait;
  logic [WAIT_CNT_W-1:0] r_cpu_wait;
  logic                  w_host_busy;
  logic                  w_cpu_busy;

  // The grantee counts as busy from its grant cycle in IDLE through its ACK.
  assign w_host_busy = (r_state == IDLE) ? (w_pick_valid && (w_pick_id == REQ_HOST))
                                         : (r_id == REQ_HOST);
  assign w_cpu_busy  = (r_state == IDLE) ? (w_pick_valid && (w_pick_id == REQ_CPU))
                                         : (r_id == REQ_CPU);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_host_wait <= '0;
      r_cpu_wait  <= '0;
    end else begin
      if (r_host_ack) r_host_wait <= '0;
      else if (host_stb_i && !w_host_busy && (r_host_wait != '1))
        r_host_wait <= r_host_wait + 1'b1;
      if (r_cpu_ack) r_cpu_wait <= '0;
      else if (cpu_stb_i && !w_cpu_busy && (r_cpu_wait != '1))
        r_cpu_wait <= r_cpu_wait + 1'b1;
    end
  end

  assign host_wait_o = r_host_wait;
  assign cpu_wait_o  = r_cpu_wait;
`else
  assign host_wait_o = '0;
  assign cpu_wait_o  = '0;
`endif

endmodule
